// File: rtl/rdyacpt_pkg.sv
// Shared types for the ready/accept round-robin arbiter: FSM state encoding
// and the index-width helper used to size requester indices.
package rdyacpt_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first requester at or above ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick
    import rdyacpt_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]            req,
    input  logic [idx_width(NREQ)-1:0] ptr,
    output logic                       gnt_vld,
    output logic [idx_width(NREQ)-1:0] gnt_idx
);

    localparam int IW = idx_width(NREQ);

    // Walk from the farthest candidate back to ptr so the nearest request wins.
    always_comb begin
        logic [IW:0]   sum_v;
        logic [IW-1:0] pos_v;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum_v   = '0;
        pos_v   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum_v = {1'b0, ptr} + (IW + 1)'(k);
            if (sum_v >= (IW + 1)'(NREQ)) begin
                sum_v = sum_v - (IW + 1)'(NREQ);
            end else begin
                sum_v = sum_v;
            end
            pos_v = sum_v[IW-1:0];
            if (req[pos_v]) begin
                gnt_vld = 1'b1;
                gnt_idx = pos_v;
            end else begin
                gnt_vld = gnt_vld;
            end
        end
    end

endmodule

// File: rtl/rdyacpt_rr_arb.sv
// Packet-aware round-robin arbiter: N ready/accept requesters merged onto one
// registered downstream port; a multi-beat packet holds the grant until its last beat.
module rdyacpt_rr_arb
    import rdyacpt_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NREQ-1:0]            up_rdy,
    input  logic [NREQ-1:0]            up_last,
    input  logic [NREQ*WIDTH-1:0]      up_data,
    output logic [NREQ-1:0]            up_acpt,
    input  logic                       dn_acpt,
    output logic                       dn_rdy,
    output logic [WIDTH-1:0]           dn_data,
    output logic                       dn_last,
    output logic [idx_width(NREQ)-1:0] dn_src
);

    localparam int            IW       = idx_width(NREQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    arb_state_e    state_r;
    logic [IW-1:0] rr_ptr_r;
    logic [IW-1:0] lock_id_r;
    logic          held_r;
    logic [IW-1:0] held_idx_r;
    logic          out_vld_r;
    logic [WIDTH-1:0] out_data_r;
    logic          out_last_r;
    logic [IW-1:0] out_src_r;

    logic          pick_vld_s;
    logic [IW-1:0] pick_idx_s;
    logic          gnt_vld_s;
    logic [IW-1:0] gnt_idx_s;
    logic          space_s;
    logic          xfer_s;
    logic          beat_last_s;
    logic [WIDTH-1:0] beat_data_s;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (i == LAST_IDX) begin
            return '0;
        end else begin
            return i + IW'(1);
        end
    endfunction

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (up_rdy),
        .ptr     (rr_ptr_r),
        .gnt_vld (pick_vld_s),
        .gnt_idx (pick_idx_s)
    );

    // Grant selection; a grant stalled on a full output stage is held so a
    // newly raised nearer request cannot steal it.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        case (state_r)
            ST_LOCKED: begin
                gnt_vld_s = up_rdy[lock_id_r];
                gnt_idx_s = lock_id_r;
            end
            ST_IDLE: begin
                if (held_r && up_rdy[held_idx_r]) begin
                    gnt_vld_s = 1'b1;
                    gnt_idx_s = held_idx_r;
                end else begin
                    gnt_vld_s = pick_vld_s;
                    gnt_idx_s = pick_idx_s;
                end
            end
            default: begin
                gnt_vld_s = 1'b0;
                gnt_idx_s = '0;
            end
        endcase
    end

    assign space_s     = ~out_vld_r | dn_acpt;
    assign xfer_s      = gnt_vld_s & space_s & reset_n;
    assign beat_last_s = up_last[gnt_idx_s];
    assign beat_data_s = up_data[int'(gnt_idx_s)*WIDTH +: WIDTH];

    // One-hot accept toward the granted requester only when a beat can move.
    always_comb begin
        up_acpt = '0;
        if (xfer_s) begin
            up_acpt[gnt_idx_s] = 1'b1;
        end else begin
            up_acpt = '0;
        end
    end

    // Packet lock FSM and round-robin pointer advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            lock_id_r  <= '0;
            held_r     <= 1'b0;
            held_idx_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        if (beat_last_s) begin
                            rr_ptr_r <= next_idx(gnt_idx_s);
                        end else begin
                            state_r   <= ST_LOCKED;
                            lock_id_r <= gnt_idx_s;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (xfer_s && beat_last_s) begin
                        state_r  <= ST_IDLE;
                        rr_ptr_r <= next_idx(lock_id_r);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            held_r     <= (state_r == ST_IDLE) & gnt_vld_s & ~space_s;
            held_idx_r <= gnt_idx_s;
        end
    end

    // Output stage: loads on transfer, drains on downstream accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld_r  <= 1'b0;
            out_data_r <= '0;
            out_last_r <= 1'b0;
            out_src_r  <= '0;
        end else if (space_s) begin
            out_vld_r <= xfer_s;
            if (xfer_s) begin
                out_data_r <= beat_data_s;
                out_last_r <= beat_last_s;
                out_src_r  <= gnt_idx_s;
            end
        end
    end

    assign dn_rdy  = out_vld_r;
    assign dn_data = out_data_r;
    assign dn_last = out_last_r;
    assign dn_src  = out_src_r;

endmodule
